// File: rtl/sequence_generator.sv
// Serial test-pattern transmitter: synchronized, debounced push-button steps
// shift a loaded pattern out MSB-first, single-shot or looping.
module sequence_generator #(
    parameter int PATTERN_W       = 16,
    parameter int LEN_W           = $clog2(PATTERN_W + 1),
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 step_raw,
    input  logic                 load,
    input  logic [PATTERN_W-1:0] pattern_in,
    input  logic [LEN_W-1:0]     len_in,
    input  logic                 loop,
    output logic                 bit_out,
    output logic                 bit_strobe,
    output logic [LEN_W-1:0]     bit_index,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PATTERN_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READY,
        S_RUN,
        S_DONE
    } state_t;

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] db_cnt;
    logic             db_level;
    logic             db_level_d;
    logic             step;

    state_t               state_q, state_n;
    logic [PATTERN_W-1:0] pat_q, pat_n;
    logic [LEN_W-1:0]     len_q, len_n;
    logic [LEN_W-1:0]     idx_q, idx_n;
    logic                 bit_q, bit_n;
    logic                 strobe_q, strobe_n;
    logic [LEN_W-1:0]     sel;
    logic [PATTERN_W-1:0] pat_shift;
    logic                 len_ok;

    // Debounce: level only follows the sample after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q     <= '0;
            db_cnt     <= '0;
            db_level   <= 1'b0;
            db_level_d <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], step_raw};
            db_level_d <= db_level;
            if (sync_q[1] == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_level <= sync_q[1];
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + CNT_W'(1);
            end
        end
    end

    assign step = db_level & ~db_level_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pat_q    <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            bit_q    <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_n;
            pat_q    <= pat_n;
            len_q    <= len_n;
            idx_q    <= idx_n;
            bit_q    <= bit_n;
            strobe_q <= strobe_n;
        end
    end

    assign len_ok    = (len_in != '0) && (len_in <= LEN_MAX);
    assign sel       = len_q - idx_q - LEN_W'(1);
    assign pat_shift = pat_q >> sel;

    always_comb begin
        state_n  = state_q;
        pat_n    = pat_q;
        len_n    = len_q;
        idx_n    = idx_q;
        bit_n    = bit_q;
        strobe_n = 1'b0;

        // A valid load always takes priority and swallows any coincident step
        if (load && len_ok) begin
            pat_n   = pattern_in;
            len_n   = len_in;
            idx_n   = '0;
            bit_n   = 1'b0;
            state_n = S_READY;
        end else if (step && (state_q == S_READY || state_q == S_RUN)) begin
            bit_n    = pat_shift[0];
            strobe_n = 1'b1;
            if (idx_q + LEN_W'(1) == len_q) begin
                if (loop) begin
                    idx_n   = '0;
                    state_n = S_RUN;
                end else begin
                    idx_n   = len_q;
                    state_n = S_DONE;
                end
            end else begin
                idx_n   = idx_q + LEN_W'(1);
                state_n = S_RUN;
            end
        end
    end

    assign bit_out    = bit_q;
    assign bit_strobe = strobe_q;
    assign bit_index  = idx_q;
    assign busy       = (state_q == S_READY) || (state_q == S_RUN);
    assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_sequence_generator.sv
// Directed bench for sequence_generator with PATTERN_W=8, DEBOUNCE_CYCLES=4.
module tb_sequence_generator;

    logic       clk = 1'b0;
    logic       reset;
    logic       step_raw;
    logic       load;
    logic [7:0] pattern_in;
    logic [3:0] len_in;
    logic       loop;
    logic       bit_out;
    logic       bit_strobe;
    logic [3:0] bit_index;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;
    int strobe_cnt = 0;
    int base;

    int single_bits[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
    int loop_bits[7]   = '{1, 1, 0, 1, 1, 0, 1};
    int loop_idx[7]    = '{1, 2, 0, 1, 2, 0, 1};

    sequence_generator #(
        .PATTERN_W(8),
        .LEN_W(4),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .step_raw(step_raw),
        .load(load),
        .pattern_in(pattern_in),
        .len_in(len_in),
        .loop(loop),
        .bit_out(bit_out),
        .bit_strobe(bit_strobe),
        .bit_index(bit_index),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bit_strobe === 1'b1) strobe_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input int hold);
        step_raw = 1'b1;
        repeat (hold) @(negedge clk);
        step_raw = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic do_load(input logic [7:0] p, input logic [3:0] l, input logic lp);
        pattern_in = p;
        len_in     = l;
        loop       = lp;
        load       = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        step_raw   = 1'b0;
        load       = 1'b0;
        pattern_in = '0;
        len_in     = '0;
        loop       = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_bit_out", bit_out, 0);
        check("rst_strobe", bit_strobe, 0);
        check("rst_index", bit_index, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Illegal load from IDLE, then a press that must be ignored
        do_load(8'hFF, 4'd0, 1'b0);
        check("illegal_busy", busy, 0);
        check("illegal_index", bit_index, 0);
        do_load(8'hFF, 4'd9, 1'b0);
        check("illegal9_busy", busy, 0);
        base = strobe_cnt;
        press(10);
        check("idle_press", strobe_cnt, base);

        // Single shot with exact first-press latency
        do_load(8'b1011_0010, 4'd8, 1'b0);
        check("load_busy", busy, 1);
        check("load_done", done, 0);
        check("load_index", bit_index, 0);
        step_raw = 1'b1;
        repeat (6) @(negedge clk);
        check("lat_early", bit_strobe, 0);
        @(negedge clk);
        check("lat_strobe", bit_strobe, 1);
        check("lat_bit", bit_out, 1);
        @(negedge clk);
        check("lat_width", bit_strobe, 0);
        repeat (2) @(negedge clk);
        step_raw = 1'b0;
        repeat (10) @(negedge clk);
        check("s_idx0", bit_index, 1);
        for (int i = 1; i < 8; i++) begin
            press(10);
            check($sformatf("s_bit%0d", i), bit_out, single_bits[i]);
            check($sformatf("s_idx%0d", i), bit_index, i + 1);
        end
        check("s_strobes", strobe_cnt, base + 8);
        check("s_done", done, 1);
        check("s_busy", busy, 0);
        press(10);
        check("s_9th_strobes", strobe_cnt, base + 8);
        check("s_9th_bit", bit_out, 0);
        check("s_9th_done", done, 1);

        // Loop and wrap
        do_load(8'b0000_0110, 4'd3, 1'b1);
        base = strobe_cnt;
        for (int i = 0; i < 7; i++) begin
            press(10);
            check($sformatf("l_bit%0d", i), bit_out, loop_bits[i]);
            check($sformatf("l_idx%0d", i), bit_index, loop_idx[i]);
            check($sformatf("l_done%0d", i), done, 0);
        end
        check("l_strobes", strobe_cnt, base + 7);

        // Bounce rejection
        base = strobe_cnt;
        for (int i = 0; i < 16; i++) begin
            step_raw = ~step_raw;
            repeat (2) @(negedge clk);
        end
        step_raw = 1'b0;
        repeat (10) @(negedge clk);
        check("bounce_only", strobe_cnt, base);
        for (int i = 0; i < 15; i++) begin
            step_raw = ~step_raw;
            repeat (2) @(negedge clk);
        end
        step_raw = 1'b1;
        repeat (10) @(negedge clk);
        step_raw = 1'b0;
        repeat (10) @(negedge clk);
        check("bounce_hold", strobe_cnt, base + 1);

        // Load coincident with the internal step pulse
        base = strobe_cnt;
        step_raw = 1'b1;
        repeat (6) @(negedge clk);
        pattern_in = 8'b1011_0010;
        len_in     = 4'd8;
        loop       = 1'b0;
        load       = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("sim_strobe", bit_strobe, 0);
        check("sim_index", bit_index, 0);
        check("sim_busy", busy, 1);
        check("sim_bit", bit_out, 0);
        repeat (3) @(negedge clk);
        step_raw = 1'b0;
        repeat (10) @(negedge clk);
        check("sim_strobes", strobe_cnt, base);

        // Held press advances exactly once
        press(100);
        check("hold_strobes", strobe_cnt, base + 1);
        check("hold_idx", bit_index, 1);
        check("hold_bit", bit_out, 1);
        press(10);
        press(10);
        check("pre_rst_idx", bit_index, 3);
        check("pre_rst_bit", bit_out, 1);

        // Asynchronous reset between edges
        #2 reset = 1'b1;
        #1;
        check("arst_bit", bit_out, 0);
        check("arst_idx", bit_index, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_strobe", bit_strobe, 0);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        base = strobe_cnt;
        press(10);
        check("arst_press", strobe_cnt, base);
        check("arst_idle_busy", busy, 0);
        do_load(8'b1011_0010, 4'd8, 1'b0);
        press(10);
        check("reload_strobes", strobe_cnt, base + 1);
        check("reload_bit", bit_out, 1);
        check("reload_idx", bit_index, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sequence_generator.md
# sequence_generator

Serial test-pattern transmitter that drives the single-bit input of the Mealy/Moore sequence-detector pair. It holds a loaded pattern and emits one bit per debounced push-button press, MSB-first, with single-shot or looping playback. It runs on the 50 MHz board clock and provides a one-cycle strobe, so detectors can be clock-enabled from it instead of clocked from a raw switch.

## Interface
- PATTERN_W, 16, maximum pattern length in bits (≥2)
- LEN_W, $clog2(PATTERN_W+1), width of length fields
- DEBOUNCE_CYCLES, 500000, consecutive stable samples required to accept a button level (10 ms at 50 MHz)

- clk  in  1  50 MHz system clock
- reset  in  1  asynchronous, active-high reset
- step_raw  in  1  raw, bouncy, asynchronous push-button; a press (rising edge) requests the next bit
- load  in  1  synchronous; captures pattern_in/len_in this cycle
- pattern_in  in  PATTERN_W  pattern; bit len_in-1 is sent first, bit 0 last
- len_in  in  LEN_W  number of bits to send, valid range 1..PATTERN_W
- loop  in  1  1 = restart from first bit after last; sampled at each step
- bit_out  out  1  current serial bit, held between steps
- bit_strobe  out  1  one-cycle pulse in the cycle bit_out takes a new value
- bit_index  out  LEN_W  count of bits emitted in the current pass (0..len)
- busy  out  1  pattern loaded and not finished
- done  out  1  single-shot pass complete

## Operation
- Input conditioning: 2-flop synchronizer on step_raw, then debouncer. A counter runs while the synchronized sample differs from the debounced level. It resets whenever the sample matches. The debounced level flips when the counter reaches DEBOUNCE_CYCLES-1. Rising edge of the debounced level = internal step pulse (1 cycle).
- State machine: IDLE, READY, RUN, DONE.
  - IDLE: no valid pattern. Steps ignored.
  - load with 1 ≤ len_in ≤ PATTERN_W (any state): capture pattern and length, bit_index=0, bit_out=0, done=0, go to READY. A load with len_in=0 or >PATTERN_W is ignored and changes nothing.
  - READY/RUN, on step: bit_out ← pattern[len-1-bit_index], bit_strobe=1, bit_index+1, go to RUN.
  - After the last bit (bit_index becomes len):
    - loop=1: bit_index ← 0, stay in RUN.
    - loop=0: go to DONE, done=1.
  - DONE: steps ignored. bit_out holds the last bit. Only load or reset leaves DONE.
- busy = 1 in READY and RUN, 0 in IDLE and DONE.
- load and step in the same cycle: load wins and the step is discarded (no strobe).
- Captured pattern is unaffected by pattern_in/len_in changes except on an accepted load.

## Timing
- Reset (async assert, held while high): state IDLE, bit_out=0, bit_strobe=0, bit_index=0, busy=0, done=0, debounced level=0, debounce counter=0, synchronizer flops=0.
- Reset mid-sequence: captured pattern is discarded. A new load is required after release.
- Step latency: step_raw goes high and stays stable before clk edge E0. bit_strobe is high and bit_out is updated after edge E0+DEBOUNCE_CYCLES+2, with ±1 cycle tolerance for sampling phase. The bench checks the exact value for its own alignment.
- bit_strobe width is exactly 1 cycle per accepted press, regardless of how long the button is held.
- Release needs DEBOUNCE_CYCLES stable low samples before another press is recognized.
- load takes effect at the next clk edge. busy/done/bit_index reflect it that same edge.

## Test plan
- Single shot: PATTERN_W=8, DEBOUNCE_CYCLES=4. Load 8'b1011_0010, len 8, loop=0. Apply 8 clean presses → bit_out sequence 1,0,1,1,0,0,1,0; 8 strobes; done=1 and busy=0 after the 8th; a 9th press gives no strobe and bit_out stays 0.
- Loop and wrap: load 3'b110 (len 3), loop=1, 7 presses → 1,1,0,1,1,0,1; bit_index wraps 3→0; done stays 0.
- Bounce rejection: toggle step_raw every 2 cycles for 30 cycles, then hold high 10 cycles → exactly one strobe. Toggling alone → zero strobes.
- Illegal/simultaneous load: load with len_in=0 from IDLE → stays IDLE, busy=0. Load asserted in the same cycle as an internal step → no strobe, bit_index=0, state READY.
- Reset mid-operation: after 3 of 8 bits, pulse reset asynchronously between edges → all outputs 0 immediately, state IDLE, next press ignored until reload.
- Hold press: press held 100 cycles → exactly one strobe, one bit advance.
